layer_priority_mux: RTL

LAYER_PRIORITY_MUX -- requirements
Module: layer_priority_mux

---
 rtl/layer_priority_mux_if.sv | 39 +++
 rtl/layer_priority_mux.sv | 122 ++++++++++++
 2 files changed

// File: rtl/layer_priority_mux_if.sv
// Pixel-side bundle for layer_priority_mux: per-layer draw/colour inputs, control
// masks and the registered, priority-resolved colour outputs.
interface layer_priority_mux_if #(
    parameter int NUM_LAYERS = 8,
    parameter int COLOR_W    = 4
);
    localparam int PIX_W = 3 * COLOR_W;
    localparam int WL_W  = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

    logic                          pixel_valid;
    logic                          frame_start;
    logic [NUM_LAYERS-1:0]         layer_dr;
    logic [NUM_LAYERS*PIX_W-1:0]   layer_rgb;
    logic [PIX_W-1:0]              bg_rgb;
    logic [NUM_LAYERS-1:0]         layer_en_req;
    logic [NUM_LAYERS-1:0]         flash_mask;
    logic                          key_en;
    logic [PIX_W-1:0]              key_rgb;
    logic [COLOR_W-1:0]            red_level;
    logic [COLOR_W-1:0]            green_level;
    logic [COLOR_W-1:0]            blue_level;
    logic                          pixel_valid_out;
    logic [WL_W-1:0]               win_layer;
    logic                          win_hit;

    modport master (
        output pixel_valid, frame_start, layer_dr, layer_rgb, bg_rgb,
               layer_en_req, flash_mask, key_en, key_rgb,
        input  red_level, green_level, blue_level, pixel_valid_out,
               win_layer, win_hit
    );

    modport slave (
        input  pixel_valid, frame_start, layer_dr, layer_rgb, bg_rgb,
               layer_en_req, flash_mask, key_en, key_rgb,
        output red_level, green_level, blue_level, pixel_valid_out,
               win_layer, win_hit
    );
endinterface

// File: rtl/layer_priority_mux.sv
// Two-stage sprite/object layer compositor: qualifies each layer (enable, blink,
// colour key), then picks the lowest-index survivor or the background.
module layer_priority_mux #(
    parameter int NUM_LAYERS   = 8,
    parameter int COLOR_W      = 4,
    parameter int FLASH_FRAMES = 16
) (
    input  logic               clk,
    input  logic               reset,
    layer_priority_mux_if.slave bus
);
    localparam int PIX_W = 3 * COLOR_W;
    localparam int WL_W  = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam logic [7:0] FC_LAST = 8'(FLASH_FRAMES - 1);

    logic [NUM_LAYERS-1:0]       r_en_active;
    logic [7:0]                  r_frame_cnt;
    logic                        r_blink_phase;

    logic [NUM_LAYERS-1:0]       r_qual;
    logic [NUM_LAYERS*PIX_W-1:0] r_layer_rgb;
    logic [PIX_W-1:0]            r_bg_rgb;
    logic                        r_pv1;

    logic [PIX_W-1:0]            r_out_rgb;
    logic [WL_W-1:0]             r_win_layer;
    logic                        r_win_hit;
    logic                        r_pv2;

    logic [NUM_LAYERS-1:0]       w_qual;
    logic [PIX_W-1:0]            w_sel_rgb;
    logic [WL_W-1:0]             w_sel_idx;
    logic                        w_sel_hit;

    // Per-layer qualification against the enable/blink state in force before any frame_start update.
    always_comb begin
        w_qual = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            w_qual[i] = bus.layer_dr[i]
                      & r_en_active[i]
                      & ~(bus.flash_mask[i] & r_blink_phase)
                      & ~(bus.key_en & (bus.layer_rgb[i*PIX_W +: PIX_W] == bus.key_rgb));
        end
    end

    // Frame-synchronous enable mask and blink timer; changes only land on frame_start.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_en_active   <= '1;
            r_frame_cnt   <= 8'd0;
            r_blink_phase <= 1'b0;
        end else if (bus.frame_start) begin
            r_en_active <= bus.layer_en_req;
            if (r_frame_cnt == FC_LAST) begin
                r_frame_cnt   <= 8'd0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_frame_cnt   <= r_frame_cnt + 8'd1;
                r_blink_phase <= r_blink_phase;
            end
        end else begin
            r_en_active   <= r_en_active;
            r_frame_cnt   <= r_frame_cnt;
            r_blink_phase <= r_blink_phase;
        end
    end

    // Stage 1: capture qualification result and all colour candidates.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_qual      <= '0;
            r_layer_rgb <= '0;
            r_bg_rgb    <= '0;
            r_pv1       <= 1'b0;
        end else begin
            r_qual      <= w_qual;
            r_layer_rgb <= bus.layer_rgb;
            r_bg_rgb    <= bus.bg_rgb;
            r_pv1       <= bus.pixel_valid;
        end
    end

    // Priority select: scanning from the top index down leaves the lowest qualified layer as winner.
    always_comb begin
        w_sel_rgb = r_bg_rgb;
        w_sel_idx = '0;
        w_sel_hit = 1'b0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (r_qual[i]) begin
                w_sel_rgb = r_layer_rgb[i*PIX_W +: PIX_W];
                w_sel_idx = WL_W'(i);
                w_sel_hit = 1'b1;
            end else begin
                w_sel_rgb = w_sel_rgb;
                w_sel_idx = w_sel_idx;
                w_sel_hit = w_sel_hit;
            end
        end
    end

    // Stage 2: registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_rgb   <= '0;
            r_win_layer <= '0;
            r_win_hit   <= 1'b0;
            r_pv2       <= 1'b0;
        end else begin
            r_out_rgb   <= w_sel_rgb;
            r_win_layer <= w_sel_idx;
            r_win_hit   <= w_sel_hit;
            r_pv2       <= r_pv1;
        end
    end

    assign bus.red_level       = r_out_rgb[PIX_W-1 -: COLOR_W];
    assign bus.green_level     = r_out_rgb[2*COLOR_W-1 -: COLOR_W];
    assign bus.blue_level      = r_out_rgb[COLOR_W-1 -: COLOR_W];
    assign bus.win_layer       = r_win_layer;
    assign bus.win_hit         = r_win_hit;
    assign bus.pixel_valid_out = r_pv2;
endmodule
